// File: rtl/imul_seq_pkg.sv
// Shared definitions for the sequential integer multiplier: default operand
// width and the controller state encoding.
package imul_seq_pkg;

  // Default operand width; legal range is 4..32 bits.
  localparam int unsigned ImulDefaultWidth = 16;

  // Controller states. The encoding is free; binary keeps the register small.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } imul_state_e;

endpackage

// File: rtl/imul_seq.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned.
//
// A request is accepted in idle. Signed operands are converted to magnitudes
// and the product sign is kept aside. WIDTH run cycles follow, one shift-add
// step each, with no early exit. The last step also loads the (conditionally
// negated) product into the result register, and the controller spends one
// cycle in done with oDone high before returning to idle.
//
// The product register holds the accumulator in its upper half and the
// remaining multiplier bits in its lower half. Each step adds the multiplicand
// magnitude into the upper half when bit 0 is set, then shifts the pair right
// by one. After WIDTH steps the whole register is the unsigned product.
module imul_seq
  import imul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = ImulDefaultWidth
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iA,
  input  logic [WIDTH-1:0]   iB,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult
);

  localparam int unsigned        CntW     = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0]    LastStep = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   OneW     = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] OneP     = (2 * WIDTH)'(1);

  imul_state_e state_q, state_d;

  logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;      // {accumulator, multiplier}
  logic [2*WIDTH-1:0] result_q, result_d;  // registered product
  logic               neg_q, neg_d;        // product sign
  logic [CntW-1:0]    cnt_q, cnt_d;        // completed steps

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [2*WIDTH-1:0] prod_final;

  // Operand magnitudes; in unsigned mode the operands pass straight through.
  always_comb begin
    a_mag = iA;
    b_mag = iB;
    if (iSigned && iA[WIDTH-1]) begin
      a_mag = ~iA + OneW;
    end
    if (iSigned && iB[WIDTH-1]) begin
      b_mag = ~iB + OneW;
    end
  end

  // Single WIDTH+1-bit adder; the carry becomes the top bit after the shift.
  always_comb begin
    sum        = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                 (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    prod_step  = {sum, prod_q[WIDTH-1:1]};
    // Negating a zero magnitude yields zero, so a zero product is never negative.
    prod_final = neg_q ? (~prod_step + OneP) : prod_step;
  end

  // Controller next state and datapath updates.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          mcand_d = a_mag;
          prod_d  = {{WIDTH{1'b0}}, b_mag};
          neg_d   = iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
          cnt_d   = '0;
          state_d = StRun;
        end
      end

      StRun: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          result_d = prod_final;
          state_d  = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode directly from the state register.
  always_comb begin
    oBusy   = (state_q != StIdle);
    oDone   = (state_q == StDone);
    oResult = result_q;
  end

  // State register with synchronous active-low reset; reset aborts any operation.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      prod_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imul_seq.sv
// Scoreboard bench for imul_seq: stimulus pushes expected products with their
// start edge; a negedge monitor pops and checks value and latency on oDone.
module tb_imul_seq;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] res;
    int             start;
  } exp_t;

  logic           Clock;
  logic           Reset;
  logic           iStart;
  logic           iSigned;
  logic [W-1:0]   iA;
  logic [W-1:0]   iB;
  logic           oBusy;
  logic           oDone;
  logic [2*W-1:0] oResult;

  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc     = 0;
  exp_t sb[$];

  imul_seq #(
    .WIDTH(W)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .iStart (iStart),
    .iSigned(iSigned),
    .iA     (iA),
    .iB     (iB),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oResult(oResult)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Edge index of the most recent rising edge.
  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every oDone must match the oldest expectation, WIDTH+1 edges late.
  always @(negedge Clock) begin
    if (oDone === 1'b1) begin
      if (sb.size() == 0) begin
        nchecks++;
        nerrors++;
        $display("FAIL spurious_done: got oDone=1 result 0x%0h, required no pulse (edge %0d)",
                 oResult, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(oResult), 64'(e.res));
        check("latency", 64'(cyc + 1 - e.start), 64'(W + 1));
      end
    end
  end

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic wait_idle();
    int n = 0;
    while (oBusy !== 1'b0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (oBusy !== 1'b0) begin
      check("idle_timeout", 64'(oBusy), 64'd0);
    end
  endtask

  task automatic start_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic push, input logic [2*W-1:0] exp);
    exp_t e;
    wait_idle();
    iStart  = 1'b1;
    iSigned = s;
    iA      = a;
    iB      = b;
    e.res   = exp;
    e.start = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge Clock);
    iStart = 1'b0;
    iA     = ~a;  // operand changes during run must not matter
    iB     = ~b;
    check("busy_in_run", 64'(oBusy), 64'd1);
  endtask

  initial begin
    int n0;
    Reset   = 1'b0;
    iStart  = 1'b1;  // reset must override a pending request
    iSigned = 1'b0;
    iA      = 16'd5;
    iB      = 16'd5;
    repeat (3) @(negedge Clock);
    check("reset_busy", 64'(oBusy), 64'd0);
    check("reset_done", 64'(oDone), 64'd0);
    check("reset_result", 64'(oResult), 64'd0);
    iStart = 1'b0;
    Reset  = 1'b1;
    @(negedge Clock);
    check("idle_busy", 64'(oBusy), 64'd0);

    // Directed vectors with hand-computed products.
    start_mul(1'b0, 16'd125,  16'd110,  1'b1, 32'h0000_35B6);
    start_mul(1'b1, 16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB);
    start_mul(1'b0, 16'hFFFD, 16'h0007, 1'b1, 32'h0006_FFEB);
    start_mul(1'b1, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
    start_mul(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001);
    start_mul(1'b1, 16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000);
    start_mul(1'b1, 16'h0000, 16'hFFFB, 1'b1, 32'h0000_0000);
    start_mul(1'b0, 16'h0000, 16'h1234, 1'b1, 32'h0000_0000);
    start_mul(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);

    // Busy guard: a second request held during run is ignored.
    start_mul(1'b0, 16'd7, 16'd6, 1'b1, 32'd42);
    iStart = 1'b1;
    iA     = 16'd2;
    iB     = 16'd2;
    repeat (8) @(negedge Clock);
    check("busy_guard_busy", 64'(oBusy), 64'd1);
    iStart = 1'b0;
    wait_idle();
    repeat (5) @(negedge Clock);
    check("result_hold", 64'(oResult), 64'd42);
    check("done_low_idle", 64'(oDone), 64'd0);

    // Reset in the middle of a run aborts with no done pulse.
    start_mul(1'b0, 16'd100, 16'd3, 1'b0, 32'd0);
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("abort_busy", 64'(oBusy), 64'd0);
    check("abort_result", 64'(oResult), 64'd0);
    check("abort_done", 64'(oDone), 64'd0);
    Reset = 1'b1;
    @(negedge Clock);
    start_mul(1'b0, 16'd7, 16'd9, 1'b1, 32'd63);

    // Back-to-back: iStart held high accepts a new multiply every W+2 edges.
    wait_idle();
    iStart  = 1'b1;
    iSigned = 1'b0;
    iA      = 16'd3;
    iB      = 16'd5;
    n0      = cyc + 1;
    sb.push_back('{res: 32'd15, start: n0});
    sb.push_back('{res: 32'd20, start: n0 + W + 2});
    sb.push_back('{res: 32'd30, start: n0 + 2 * (W + 2)});
    @(negedge Clock);
    iA = 16'd4;
    while (cyc < n0 + W + 2) @(negedge Clock);
    iA = 16'd6;
    while (cyc < n0 + 2 * (W + 2)) @(negedge Clock);
    iStart = 1'b0;

    // Drain the scoreboard, bounded.
    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge Clock);
        n++;
      end
    end
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    repeat (4) @(negedge Clock);
    check("final_idle", 64'(oBusy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
